// File: rtl/cram_pkg.sv
// Shared types and constants for the CellularRAM data-memory controller.
package cram_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC_LO = 3'd1,
    S_GAP    = 3'd2,
    S_ACC_HI = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Asynchronous-mode pin ties.
  localparam logic ADV_N_TIE = 1'b0;
  localparam logic CRE_TIE   = 1'b0;
  localparam logic CLK_TIE   = 1'b0;

endpackage

// File: rtl/cram_ctrl.sv
// Sequences one 32-bit CPU word access as two asynchronous 16-bit CellularRAM
// accesses; completion is signalled by a one-cycle ack.
module cram_ctrl
  import cram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_dq_o,
  input  logic [15:0] mem_dq_i,
  output logic        mem_dq_oe,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_lb_n,
  output logic        mem_ub_n,
  output logic        mem_adv_n,
  output logic        mem_cre,
  output logic        mem_clk
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             we_q;
  logic [21:0]      word_q;
  logic [15:0]      wdata_hi_q;
  logic [15:0]      buf_lo;
  logic             start;
  logic             we_next;
  logic             acc_next;
  logic             addr_unused;

  assign mem_adv_n   = ADV_N_TIE;
  assign mem_cre     = CRE_TIE;
  assign mem_clk     = CLK_TIE;
  assign addr_unused = ^{addr[31:24], addr[1:0]};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    start      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          start      = 1'b1;
          state_next = S_ACC_LO;
          cnt_next   = CNT_LOAD;
        end
      end
      S_ACC_LO: begin
        if (cnt == '0) state_next = S_GAP;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      S_GAP: begin
        state_next = S_ACC_HI;
        cnt_next   = CNT_LOAD;
      end
      S_ACC_HI: begin
        if (cnt == '0) state_next = S_DONE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Pad strobes are registered from the next state so they line up with it.
    we_next  = start ? we : we_q;
    acc_next = (state_next == S_ACC_LO) || (state_next == S_ACC_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      buf_lo     <= '0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_dq_o   <= '0;
      mem_dq_oe  <= 1'b0;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      mem_lb_n   <= 1'b1;
      mem_ub_n   <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ack       <= (state_next == S_DONE);
      busy      <= (state_next != S_IDLE);
      mem_ce_n  <= ~acc_next;
      mem_lb_n  <= ~acc_next;
      mem_ub_n  <= ~acc_next;
      mem_oe_n  <= ~(acc_next & ~we_next);
      mem_we_n  <= ~(acc_next & we_next);
      mem_dq_oe <= acc_next & we_next;
      if (start) begin
        we_q       <= we;
        word_q     <= addr[23:2];
        wdata_hi_q <= wdata[31:16];
        mem_addr   <= {addr[23:2], 1'b0};
        mem_dq_o   <= wdata[15:0];
      end else if (state == S_GAP) begin
        mem_addr <= {word_q, 1'b1};
        mem_dq_o <= wdata_hi_q;
      end
      if (state == S_ACC_LO && cnt == '0 && !we_q) buf_lo <= mem_dq_i;
    end
  end

  // rdata survives a reset that aborts an access; it is only cleared from idle.
  // The high half is merged straight in so the word is visible during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (!busy) rdata <= '0;
    end else if (state == S_ACC_HI && cnt == '0 && !we_q) begin
      rdata <= {mem_dq_i, buf_lo};
    end
  end

endmodule

// File: tb/tb_cram_ctrl.sv
// Directed bench for cram_ctrl: per-cycle pad checks, RAM model, ack scoreboard.
module tb_cram_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, busy;
  logic [22:0] mem_addr;
  logic [15:0] mem_dq_o, mem_dq_i;
  logic        mem_dq_oe, ce_n, oe_n, we_n, lb_n, ub_n, adv_n, cre, mclk;

  logic        req2 = 1'b0, req15 = 1'b0;
  logic        ack2, ack15, we_n2, we_n15;
  logic [22:0] maddr2, maddr15;
  logic [31:0] unused_rd2, unused_rd15;
  logic [15:0] unused_dq2, unused_dq15;
  logic [10:0] unused_p2, unused_p15;

  cram_ctrl #(.ACCESS_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .mem_addr(mem_addr),
    .mem_dq_o(mem_dq_o), .mem_dq_i(mem_dq_i), .mem_dq_oe(mem_dq_oe),
    .mem_ce_n(ce_n), .mem_oe_n(oe_n), .mem_we_n(we_n), .mem_lb_n(lb_n),
    .mem_ub_n(ub_n), .mem_adv_n(adv_n), .mem_cre(cre), .mem_clk(mclk)
  );

  cram_ctrl #(.ACCESS_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(1'b1), .addr(32'h0000_0040),
    .wdata(32'h1111_2222), .rdata(unused_rd2), .ack(ack2), .busy(unused_p2[0]),
    .mem_addr(maddr2), .mem_dq_o(unused_dq2), .mem_dq_i(16'h0000),
    .mem_dq_oe(unused_p2[1]), .mem_ce_n(unused_p2[2]), .mem_oe_n(unused_p2[3]),
    .mem_we_n(we_n2), .mem_lb_n(unused_p2[4]), .mem_ub_n(unused_p2[5]),
    .mem_adv_n(unused_p2[6]), .mem_cre(unused_p2[7]), .mem_clk(unused_p2[8])
  );

  cram_ctrl #(.ACCESS_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset), .req(req15), .we(1'b1), .addr(32'h0000_0040),
    .wdata(32'h1111_2222), .rdata(unused_rd15), .ack(ack15), .busy(unused_p15[0]),
    .mem_addr(maddr15), .mem_dq_o(unused_dq15), .mem_dq_i(16'h0000),
    .mem_dq_oe(unused_p15[1]), .mem_ce_n(unused_p15[2]), .mem_oe_n(unused_p15[3]),
    .mem_we_n(we_n15), .mem_lb_n(unused_p15[4]), .mem_ub_n(unused_p15[5]),
    .mem_adv_n(unused_p15[6]), .mem_cre(unused_p15[7]), .mem_clk(unused_p15[8])
  );

  assign unused_p2[10:9]  = 2'b00;
  assign unused_p15[10:9] = 2'b00;

  always #10 clk = ~clk;

  // Asynchronous RAM model on the main instance's pads.
  logic [15:0] ram [0:255];
  always @(posedge clk) if (!ce_n && !we_n) ram[mem_addr[7:0]] <= mem_dq_o;
  assign mem_dq_i = (!ce_n && !oe_n) ? ram[mem_addr[7:0]] : 16'h0000;

  typedef struct {
    string       tag;
    int          ack_k;
    logic [31:0] rd;
    bit          is_rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe, busy, ack}
  function automatic logic [7:0] pads();
    return {ce_n, oe_n, we_n, lb_n, ub_n, mem_dq_oe, busy, ack};
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    k++;
    if (ack) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'(k), 32'(0));
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_ack_cycle"}, 32'(k), 32'(e.ack_k));
        if (e.is_rd) chk({e.tag, "_rdata"}, rdata, e.rd);
      end
    end
  endtask

  task automatic phase_chk(input string tag, input bit w, input logic [22:0] base,
                           input logic [31:0] wd);
    bit          acc, hi;
    logic [7:0]  ep;
    acc = (k >= 1 && k <= N) || (k >= N + 2 && k <= 2 * N + 1);
    hi  = (k >= N + 2);
    ep  = {~acc, ~(acc & ~w), ~(acc & w), ~acc, ~acc, acc & w, 1'b1, (k == 2 * N + 2)};
    chk($sformatf("%s_pads_k%0d", tag, k), 32'(pads()), 32'(ep));
    chk($sformatf("%s_addr_k%0d", tag, k), 32'(mem_addr), 32'(base | 23'(hi)));
    if (w && acc) chk($sformatf("%s_dq_k%0d", tag, k), 32'(mem_dq_o),
                      32'(hi ? wd[31:16] : wd[15:0]));
  endtask

  task automatic run_access(input string tag, input bit w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [22:0] base,
                            input logic [31:0] exp_rd);
    we = w; addr = a; wdata = wd; req = 1'b1; k = 0;
    sb.push_back('{tag, 2 * N + 2, exp_rd, !w});
    for (int i = 1; i <= 2 * N + 2; i++) begin
      step();
      phase_chk(tag, w, base, wd);
    end
    req = 1'b0;
    step();
    chk({tag, "_idle_pads"}, 32'(pads()), 32'(8'b11111000));
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    int ack2_k, ack15_k, lo2, hi2, lo15, hi15;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_pads", 32'(pads()), 32'(8'b11111000));
    chk("reset_rdata", rdata, 32'h0000_0000);
    chk("reset_addr", 32'(mem_addr), 32'(0));
    chk("reset_dq_o", 32'(mem_dq_o), 32'(0));
    chk("tie_pins", 32'({adv_n, cre, mclk}), 32'(0));

    // Masked address lands on the same word as 0x10.
    run_access("wr_mask", 1'b1, 32'hFF00_0013, 32'h1234_5678, 23'h000008, 32'h0);
    run_access("rd_mask", 1'b0, 32'h0000_0010, 32'h0, 23'h000008, 32'h1234_5678);
    run_access("wr_beef", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 23'h000008, 32'h0);
    run_access("rd_beef", 1'b0, 32'h0000_0010, 32'h0, 23'h000008, 32'hDEAD_BEEF);

    // req held 2 cycles past ack starts a second read; a pulse in ACC_HI is ignored.
    we = 1'b0; addr = 32'h0000_0010; req = 1'b1; k = 0;
    sb.push_back('{"held1", 2 * N + 2, 32'hDEAD_BEEF, 1'b1});
    sb.push_back('{"held2", 4 * N + 5, 32'hDEAD_BEEF, 1'b1});
    for (int i = 1; i <= 24; i++) begin
      step();
      if (k == 2 * N + 3) chk("held_idle_gap", 32'(busy), 32'(0));
      if (k == 2 * N + 4) chk("held_restart", 32'({busy, ce_n}), 32'(2'b10));
      if (k == 2 * N + 5) req = 1'b0;
      if (k == 3 * N + 5) req = 1'b1;
      if (k == 3 * N + 6) req = 1'b0;
      if (k == 4 * N + 6) chk("held_no_third_a", 32'(busy), 32'(0));
      if (k == 4 * N + 7) chk("held_no_third_b", 32'(busy), 32'(0));
    end
    chk("held_sb_drained", 32'(sb.size()), 32'(0));

    // Reset in the 2nd cycle of ACC_HI of a read.
    we = 1'b0; addr = 32'h0000_0010; req = 1'b1; k = 0;
    for (int i = 1; i <= N + 3; i++) step();
    chk("rst_mid_in_acc", 32'(ce_n), 32'(0));
    reset = 1'b1;
    step();
    reset = 1'b0; req = 1'b0;
    chk("rst_mid_pads", 32'(pads()), 32'(8'b11111000));
    chk("rst_mid_rdata", rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 12; i++) step();
    chk("rst_mid_quiet", 32'(busy), 32'(0));

    // Parameter sweep: ACCESS_CYCLES = 2 and 15 side by side.
    ack2_k = -1; ack15_k = -1; lo2 = 0; hi2 = 0; lo15 = 0; hi15 = 0;
    req2 = 1'b1; req15 = 1'b1; k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (!we_n2)  begin if (maddr2[0])  hi2++;  else lo2++;  end
      if (!we_n15) begin if (maddr15[0]) hi15++; else lo15++; end
      if (ack2 && ack2_k < 0)   begin ack2_k = k;  req2 = 1'b0;  end
      if (ack15 && ack15_k < 0) begin ack15_k = k; req15 = 1'b0; end
    end
    chk("n2_ack_latency", 32'(ack2_k), 32'(6));
    chk("n15_ack_latency", 32'(ack15_k), 32'(32));
    chk("n2_we_low_lo", 32'(lo2), 32'(2));
    chk("n2_we_low_hi", 32'(hi2), 32'(2));
    chk("n15_we_low_lo", 32'(lo15), 32'(15));
    chk("n15_we_low_hi", 32'(hi15), 32'(15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cram_ctrl.md
# cram_ctrl

Data-memory controller that lets the single-cycle MIPS core use the onboard Micron CellularRAM in place of on-chip dmem. It accepts one 32-bit word read or write from the CPU side and sequences it as two asynchronous-mode 16-bit CellularRAM accesses, each lasting a programmable number of clocks. It signals completion with a one-cycle ack, and the core stalls until that ack arrives. It sits between the mips instance (aluout / writedata / readdata / memwrite) and the FPGA pins of the RAM.

## Interface
Parameters:
- ACCESS_CYCLES, 4, clocks each half-word access holds its strobes active; 4 × 20 ns covers 70 ns tRC/tWC at 50 MHz; legal range 2..15.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- req  in  1  access request; held high until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  32  byte address; bits [1:0] and [31:24] are ignored.
- wdata  in  32  write word; sampled with req.
- rdata  out  32  last read word.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- mem_addr  out  23  half-word address = {addr[23:2], half}.
- mem_dq_o  out  16  write data to the pad.
- mem_dq_i  in  16  read data from the pad.
- mem_dq_oe  out  1  pad output enable.
- mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n  out  1 each  active-low strobes.
- mem_adv_n  out  1  tied 0 (asynchronous mode).
- mem_cre  out  1  tied 0.
- mem_clk  out  1  tied 0.

## Operation
- States: IDLE → ACC_LO → GAP → ACC_HI → DONE → IDLE.
- IDLE:
  - All strobes high, mem_dq_oe = 0.
  - When req = 1, latch we, addr[23:2] and wdata. Load the counter with ACCESS_CYCLES−1 and go to ACC_LO.
- ACC_LO / ACC_HI:
  - half = 0 in ACC_LO, 1 in ACC_HI.
  - ce_n = lb_n = ub_n = 0.
  - Read: oe_n = 0.
  - Write: we_n = 0, dq_oe = 1, dq_o = wdata[15:0] in ACC_LO and wdata[31:16] in ACC_HI.
  - The counter decrements every cycle. When it reaches 0:
    - a read captures mem_dq_i into the matching half of an internal buffer;
    - the state advances.
- GAP: exactly one cycle with all strobes high and dq_oe = 0 (recovery / bus turnaround). Then reload the counter and go to ACC_HI.
- DONE:
  - ack = 1 for one cycle.
  - On a read, rdata ← buffer; rdata holds that value until the next read's DONE.
  - Next state is IDLE.
- req is ignored in every state except IDLE. The requester must drop req in the cycle after it sees ack. If req is still high in IDLE, a new access starts.
- No byte/half-word writes: lb_n and ub_n always equal ce_n.

## Timing
- Reset values: state IDLE, rdata 0, ack 0, busy 0, mem_dq_oe 0, mem_ce_n / oe_n / we_n / lb_n / ub_n = 1, mem_addr 0, mem_dq_o 0.
- All memory outputs are registered, so no combinational path runs from req to the pads.
- Latency: if req is sampled in cycle T, ack is high in cycle T + 2·ACCESS_CYCLES + 2. That is cycle T+10 at the default.
- Read data is sampled on the last cycle of each ACC state, at ACCESS_CYCLES·20 ns after the strobes fall.
- Writes:
  - we_n and dq_oe deassert on the same edge (tDH = 0).
  - mem_addr is stable for the whole ACC state plus the following GAP/DONE cycle.
- Reset asserted mid-access: on the next edge, strobes go high, dq_oe = 0, ack = 0 and state = IDLE. The transaction is discarded and rdata is unchanged.
- busy is high from T+1 through the DONE cycle.

## Structure
- Package cram_pkg holds:
  - the state encoding (5 states, 3 bits);
  - localparam CNT_W = 4;
  - the constants for the tied pins (adv_n, cre, clk).
- Single module. The access counter is inline; no sub-module is warranted.
- Instantiated in cpu_top in place of the commented-out dmem. The core's stall input is driven by busy | (req & ~ack).

## Test plan
- Reset idle: hold reset for 3 cycles, then release → all strobes 1, dq_oe 0, rdata 0x00000000, busy 0.
- Write, then read back:
  - write addr 0x00000010, wdata 0xDEADBEEF → mem_addr 0x000008 with dq_o 0xBEEF for 4 cycles, GAP, then mem_addr 0x000009 with dq_o 0xDEAD; ack at T+10.
  - Read the same address against a RAM model → rdata 0xDEADBEEF at ack.
- Address masking: addr 0xFF000013 → mem_addr 0x000008 then 0x000009.
- Parameter sweep: ACCESS_CYCLES = 2 → ack at T+6; ACCESS_CYCLES = 15 → ack at T+32; we_n low exactly 2 / 15 cycles per half.
- Held req: keep req high for 2 cycles after ack → a second access starts in the cycle after IDLE is re-entered. A req pulse during ACC_HI is ignored.
- Reset mid-access: assert reset in the 2nd cycle of ACC_HI of a read → the next edge shows strobes high and state IDLE, no ack, and rdata keeps its previous value 0xDEADBEEF.
